// File: rtl/nios_system_pio_pkg.sv
// Shared definitions for the nios_system PIO slaves (input and output ports):
// register window addresses and small elaboration-time helpers.
package nios_system_pio_pkg;

   localparam int unsigned PIO_DATA_W = 32;

   localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
   localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
   localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

   // Counter must reach DEBOUNCE_CYCLES-1, with one spare bit of headroom.
   function automatic int unsigned pio_cnt_width(input int unsigned cycles);
      return int'($clog2(cycles)) + 1;
   endfunction

endpackage

// File: rtl/nios_system_block_status_in_if.sv
// Avalon-MM slave bus bundle for the status input PIO (word-addressed, 2-bit window).
interface nios_system_block_status_in_if;

   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata,
      input  irq
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata,
      output irq
   );

endinterface

// File: rtl/nios_system_pio_debounce.sv
// Two-flop synchronizer followed by a whole-vector debouncer: deb follows
// the synchronized input only after it has held steady for DEBOUNCE_CYCLES.
module nios_system_pio_debounce
   import nios_system_pio_pkg::*;
#(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] deb
);

   localparam int unsigned      CNT_W    = pio_cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;
   logic [WIDTH-1:0] cand_q, cand_d;
   logic [WIDTH-1:0] deb_q,  deb_d;
   logic [CNT_W-1:0] cnt_q,  cnt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
         cand_q <= '0;
         deb_q  <= '0;
         cnt_q  <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         cand_q <= cand_d;
         deb_q  <= deb_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      meta_d = in_port;
      sync_d = meta_q;
      cand_d = cand_q;
      deb_d  = deb_q;
      cnt_d  = cnt_q;
      // Any movement of the synchronized input restarts the stability count.
      if (sync_q != cand_q) begin
         cand_d = sync_q;
         cnt_d  = '0;
      end else if (cand_q != deb_q) begin
         if (cnt_q == CNT_LAST) begin
            deb_d = cand_q;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         cnt_d = '0;
      end
   end

   assign deb = deb_q;

endmodule

// File: rtl/nios_system_block_status_in.sv
// Avalon-MM status input PIO: debounced data, irq mask and write-1-to-clear
// rising-edge capture, with registered read data.
module nios_system_block_status_in
   import nios_system_pio_pkg::*;
#(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [WIDTH-1:0]             in_port,
   nios_system_block_status_in_if.slave bus
);

   logic [WIDTH-1:0]      deb;
   logic [WIDTH-1:0]      deb_dly_q, deb_dly_d;
   logic [WIDTH-1:0]      irqmask_q, irqmask_d;
   logic [WIDTH-1:0]      ec_q, ec_d;
   logic [PIO_DATA_W-1:0] readdata_q, readdata_d;
   logic [WIDTH-1:0]      rise;
   logic [WIDTH-1:0]      clr;
   logic                  wr_en;
   logic                  unused_wdata;

   nios_system_pio_debounce #(
      .WIDTH           (WIDTH),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .in_port (in_port),
      .deb     (deb)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         deb_dly_q  <= '0;
         irqmask_q  <= '0;
         ec_q       <= '0;
         readdata_q <= '0;
      end else begin
         deb_dly_q  <= deb_dly_d;
         irqmask_q  <= irqmask_d;
         ec_q       <= ec_d;
         readdata_q <= readdata_d;
      end
   end

   always_comb begin
      wr_en     = bus.chipselect & ~bus.write_n;
      deb_dly_d = deb;
      rise      = deb & ~deb_dly_q;
      irqmask_d = irqmask_q;
      clr       = '0;
      if (wr_en && (bus.address == PIO_ADDR_IRQMASK)) begin
         irqmask_d = bus.writedata[WIDTH-1:0];
      end
      if (wr_en && (bus.address == PIO_ADDR_EDGECAP)) begin
         clr = bus.writedata[WIDTH-1:0];
      end
      // A rise landing on the same edge as its clear stays captured.
      ec_d = rise | (ec_q & ~clr);
   end

   always_comb begin
      readdata_d = '0;
      case (bus.address)
         PIO_ADDR_DATA:    readdata_d[WIDTH-1:0] = deb;
         PIO_ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
         PIO_ADDR_EDGECAP: readdata_d[WIDTH-1:0] = ec_q;
         default:          readdata_d = '0;
      endcase
   end

   assign unused_wdata = ^bus.writedata;

   assign bus.readdata = readdata_q;
   assign bus.irq      = |(ec_q & irqmask_q);

endmodule
